// File: rtl/layer_compositor.sv
// layer_compositor: priority-based compositor for NUM_LAYERS sprite/background
// layers. Configuration is double-buffered (shadow -> active at frame_tick),
// pixels flow through a two-stage pipeline, and per-layer overlap flags are
// accumulated per frame and published at each frame_tick.
module layer_compositor #(
  parameter int                  NUM_LAYERS = 4,
  parameter int                  COLOR_W    = 12,
  parameter int                  PRIO_W     = 3,
  parameter logic [COLOR_W-1:0]  BG_COLOR   = 12'h000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          video_on,
  input  logic                          frame_tick,
  input  logic [NUM_LAYERS-1:0]         layer_on,
  input  logic [NUM_LAYERS*COLOR_W-1:0] layer_color,
  input  logic                          cfg_wr,
  input  logic [2:0]                    cfg_idx,
  input  logic [PRIO_W-1:0]             cfg_prio,
  input  logic                          cfg_en,
  output logic                          cfg_pending,
  output logic [COLOR_W-1:0]            rgb,
  output logic                          video_on_out,
  output logic [NUM_LAYERS-1:0]         collide,
  output logic                          frame_done
);

  // True when at least two bits of the visibility vector are set.
  function automatic logic has_overlap(input logic [NUM_LAYERS-1:0] v);
    return |(v & (v - NUM_LAYERS'(1)));
  endfunction

  // Configuration state
  logic [NUM_LAYERS-1:0][PRIO_W-1:0] shadow_prio_q;
  logic [NUM_LAYERS-1:0]             shadow_en_q;
  logic [NUM_LAYERS-1:0][PRIO_W-1:0] act_prio_q;
  logic [NUM_LAYERS-1:0]             act_en_q;
  logic                              pending_q;

  // Stage 1: visibility, colours and the rank snapshot that goes with them
  logic [NUM_LAYERS-1:0]             vis1_q;
  logic [NUM_LAYERS*COLOR_W-1:0]     color1_q;
  logic [NUM_LAYERS-1:0][PRIO_W-1:0] prio1_q;
  logic                              vid1_q;

  // Stage 2 / outputs
  logic [COLOR_W-1:0]                rgb_q;
  logic [COLOR_W-1:0]                rgb_d;
  logic                              vid2_q;

  // Collision tracking
  logic [NUM_LAYERS-1:0]             hit_q;
  logic [NUM_LAYERS-1:0]             hit_d;
  logic [NUM_LAYERS-1:0]             collide_q;
  logic                              frame_done_q;

  logic                              cfg_ok_s;
  logic [NUM_LAYERS-1:0]             overlap_bits_s;

  assign cfg_ok_s       = cfg_wr && (32'(cfg_idx) < NUM_LAYERS);
  assign overlap_bits_s = has_overlap(vis1_q) ? vis1_q : '0;

  // Shadow/active configuration registers and the pending flag.
  // Active copies the shadow value from before this edge, so a write that
  // coincides with frame_tick waits for the next tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        shadow_prio_q[i] <= PRIO_W'(i);
        act_prio_q[i]    <= PRIO_W'(i);
      end
      shadow_en_q <= '1;
      act_en_q    <= '1;
      pending_q   <= 1'b0;
    end else begin
      if (frame_tick) begin
        act_prio_q <= shadow_prio_q;
        act_en_q   <= shadow_en_q;
      end
      for (int i = 0; i < NUM_LAYERS; i++) begin
        if (cfg_ok_s && (cfg_idx == 3'(i))) begin
          shadow_prio_q[i] <= cfg_prio;
          shadow_en_q[i]   <= cfg_en;
        end
      end
      if (cfg_ok_s) begin
        pending_q <= 1'b1;
      end else if (frame_tick) begin
        pending_q <= 1'b0;
      end
    end
  end

  // Stage 1 pipeline register: gate each layer by its enable and video_on.
  always_ff @(posedge clk) begin
    if (reset) begin
      vis1_q   <= '0;
      color1_q <= '0;
      prio1_q  <= '0;
      vid1_q   <= 1'b0;
    end else begin
      vis1_q   <= layer_on & act_en_q & {NUM_LAYERS{video_on}};
      color1_q <= layer_color;
      prio1_q  <= act_prio_q;
      vid1_q   <= video_on;
    end
  end

  // Stage 2 selection: lowest rank among visible layers, lower index on ties.
  always_comb begin
    logic [PRIO_W-1:0]  best_prio;
    logic [COLOR_W-1:0] sel_color;
    logic               found;
    logic               take;
    best_prio = '1;
    sel_color = '0;
    found     = 1'b0;
    take      = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      take      = vis1_q[i] && (!found || (prio1_q[i] < best_prio));
      best_prio = take ? prio1_q[i] : best_prio;
      sel_color = take ? color1_q[i*COLOR_W +: COLOR_W] : sel_color;
      found     = found | take;
    end
    if (!vid1_q) begin
      rgb_d = '0;
    end else if (found) begin
      rgb_d = sel_color;
    end else begin
      rgb_d = BG_COLOR;
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q  <= '0;
      vid2_q <= 1'b0;
    end else begin
      rgb_q  <= rgb_d;
      vid2_q <= vid1_q;
    end
  end

  // Next sticky-hit value: restart on frame_tick but keep this cycle's overlap.
  always_comb begin
    hit_d = hit_q;
    if (frame_tick) begin
      hit_d = overlap_bits_s;
    end else begin
      hit_d = hit_q | overlap_bits_s;
    end
  end

  // Collision bookkeeping: sticky hits, published collide and frame_done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_q        <= '0;
      collide_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hit_q        <= hit_d;
      frame_done_q <= frame_tick;
      if (frame_tick) begin
        collide_q <= hit_q;
      end
    end
  end

  assign cfg_pending  = pending_q;
  assign rgb          = rgb_q;
  assign video_on_out = vid2_q;
  assign collide      = collide_q;
  assign frame_done   = frame_done_q;

endmodule
